// File: rtl/sp_sram_burst_param.sv
// Multi-bank single-port coefficient SRAM with power-up zero-clear, handshaked burst write
// and wrapping burst read alongside plain single-word access.
module sp_sram_burst_param #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned ADDR_DEPTH = 33,
    parameter int unsigned ADDR_WIDTH = 6,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned CH_WIDTH   = 2
) (
    input  logic                         iClk_12M,
    input  logic                         iRst,
    input  logic                         iClrStart,
    input  logic                         iCsnRam,
    input  logic                         iWrnRam,
    input  logic [CH_WIDTH-1:0]          iChSel,
    input  logic [ADDR_WIDTH-1:0]        iAddrRam,
    input  logic signed [DATA_WIDTH-1:0] iWrDtRam,
    output logic signed [DATA_WIDTH-1:0] oRdDtRam,
    output logic                         oRdVld,
    input  logic                         iBurstStart,
    input  logic                         iBurstWrn,
    input  logic [CH_WIDTH-1:0]          iBurstCh,
    input  logic [ADDR_WIDTH-1:0]        iBurstBase,
    input  logic [ADDR_WIDTH-1:0]        iBurstLen,
    input  logic signed [DATA_WIDTH-1:0] iBurstDt,
    input  logic                         iBurstDtVld,
    output logic                         oBurstDtRdy,
    output logic signed [DATA_WIDTH-1:0] oBurstRdDt,
    output logic                         oBurstRdVld,
    output logic                         oBusy,
    output logic                         oDone,
    output logic                         oErr
);

    typedef enum logic [2:0] {StIdle, StClear, StBurstWr, StBurstRd, StDone} stateT;

    localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(ADDR_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] One      = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [NUM_CH][ADDR_DEPTH];

    stateT                 state, stateNext;
    logic [ADDR_WIDTH-1:0] addr, addrNext, len, lenNext;
    logic [CH_WIDTH-1:0]   ch, chNext;
    logic                  memWe, memClr, errNext, sglRd, burstBad, sglBad;
    logic [CH_WIDTH-1:0]   memCh;
    logic [ADDR_WIDTH-1:0] memIdx, sglIdx, burstIdx, addrInc;
    logic [DATA_WIDTH-1:0] memWd;

    assign burstBad = (iBurstLen == '0) || (iBurstLen > LastAddr) || (iBurstBase == '0) ||
                      (iBurstBase > LastAddr) || (32'(iBurstCh) >= NUM_CH);
    assign sglBad   = (iAddrRam == '0) || (iAddrRam > LastAddr) || (32'(iChSel) >= NUM_CH);
    assign sglIdx   = iAddrRam - One;
    assign burstIdx = addr - One;
    assign addrInc  = (addr == LastAddr) ? One : addr + One;

    always_comb begin
        stateNext = state;
        addrNext  = addr;
        lenNext   = len;
        chNext    = ch;
        memWe     = 1'b0;
        memClr    = 1'b0;
        memCh     = iChSel;
        memIdx    = sglIdx;
        memWd     = iWrDtRam;
        errNext   = 1'b0;
        sglRd     = 1'b0;
        unique case (state)
            StClear: begin
                // addr counts 0..DEPTH-1 here and doubles as the zero-based row index
                memWe    = 1'b1;
                memClr   = 1'b1;
                memIdx   = addr;
                memWd    = '0;
                addrNext = addr + One;
                if (addr == LastAddr - One) begin
                    stateNext = StDone;
                    addrNext  = '0;
                end
            end
            StIdle: begin
                if (iClrStart) begin
                    stateNext = StClear;
                    addrNext  = '0;
                end else if (iBurstStart) begin
                    if (burstBad) begin
                        errNext = 1'b1;
                    end else begin
                        addrNext  = iBurstBase;
                        lenNext   = iBurstLen;
                        chNext    = iBurstCh;
                        stateNext = iBurstWrn ? StBurstRd : StBurstWr;
                    end
                end else if (!iCsnRam) begin
                    if (sglBad)        errNext = 1'b1;
                    else if (!iWrnRam) memWe   = 1'b1;
                    else               sglRd   = 1'b1;
                end
            end
            StBurstWr: begin
                memCh  = ch;
                memIdx = burstIdx;
                memWd  = iBurstDt;
                if (iBurstDtVld) begin
                    memWe    = 1'b1;
                    addrNext = addrInc;
                    lenNext  = len - One;
                    if (len == One) stateNext = StDone;
                end
            end
            StBurstRd: begin
                addrNext = addrInc;
                lenNext  = len - One;
                if (len == One) stateNext = StDone;
            end
            StDone:  stateNext = StIdle;
            default: stateNext = StIdle;
        endcase
    end

    // Writes are suppressed while reset is held so an abandoned burst cannot land late.
    always_ff @(posedge iClk_12M) begin
        if (memWe && !iRst) begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (memClr || (c == int'(memCh))) mem[c][memIdx] <= memWd;
            end
        end
    end

    always_ff @(posedge iClk_12M or posedge iRst) begin
        if (iRst) begin
            state       <= StClear;
            addr        <= '0;
            len         <= '0;
            ch          <= '0;
            oRdDtRam    <= '0;
            oRdVld      <= 1'b0;
            oBurstRdDt  <= '0;
            oBurstRdVld <= 1'b0;
            oBurstDtRdy <= 1'b0;
            oBusy       <= 1'b0;
            oDone       <= 1'b0;
            oErr        <= 1'b0;
        end else begin
            state       <= stateNext;
            addr        <= addrNext;
            len         <= lenNext;
            ch          <= chNext;
            oRdVld      <= sglRd;
            if (sglRd) oRdDtRam <= mem[iChSel][sglIdx];
            oBurstRdVld <= (state == StBurstRd);
            if (state == StBurstRd) oBurstRdDt <= mem[ch][burstIdx];
            oBurstDtRdy <= (stateNext == StBurstWr);
            oBusy       <= (stateNext != StIdle);
            oDone       <= (stateNext == StDone);
            oErr        <= errNext;
        end
    end

endmodule

// File: tb/tb_sp_sram_burst_param.sv
// Randomised self-checking bench for sp_sram_burst_param against an array-based memory model.
module tb_sp_sram_burst_param;

    localparam int DW = 16;
    localparam int AD = 33;
    localparam int AW = 6;
    localparam int NC = 4;
    localparam int CW = 2;

    logic          iClk_12M = 1'b0;
    logic          iRst, iClrStart, iCsnRam, iWrnRam, iBurstStart, iBurstWrn, iBurstDtVld;
    logic [CW-1:0] iChSel, iBurstCh;
    logic [AW-1:0] iAddrRam, iBurstBase, iBurstLen;
    logic [DW-1:0] iWrDtRam, iBurstDt, oRdDtRam, oBurstRdDt;
    logic          oRdVld, oBurstDtRdy, oBurstRdVld, oBusy, oDone, oErr;

    logic [DW-1:0] model [NC][AD+1];
    int checks = 0;
    int failures = 0;
    int busyCnt, doneIdx, op, rc, ra, rl;

    always #5 iClk_12M = ~iClk_12M;

    sp_sram_burst_param dut (
        .iClk_12M    (iClk_12M),
        .iRst        (iRst),
        .iClrStart   (iClrStart),
        .iCsnRam     (iCsnRam),
        .iWrnRam     (iWrnRam),
        .iChSel      (iChSel),
        .iAddrRam    (iAddrRam),
        .iWrDtRam    (iWrDtRam),
        .oRdDtRam    (oRdDtRam),
        .oRdVld      (oRdVld),
        .iBurstStart (iBurstStart),
        .iBurstWrn   (iBurstWrn),
        .iBurstCh    (iBurstCh),
        .iBurstBase  (iBurstBase),
        .iBurstLen   (iBurstLen),
        .iBurstDt    (iBurstDt),
        .iBurstDtVld (iBurstDtVld),
        .oBurstDtRdy (oBurstDtRdy),
        .oBurstRdDt  (oBurstRdDt),
        .oBurstRdVld (oBurstRdVld),
        .oBusy       (oBusy),
        .oDone       (oDone),
        .oErr        (oErr)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic int wrap(input int a);
        return (a == AD) ? 1 : a + 1;
    endfunction

    task automatic idleInputs();
        iClrStart = 0; iCsnRam = 1; iWrnRam = 1; iChSel = '0; iAddrRam = '0; iWrDtRam = '0;
        iBurstStart = 0; iBurstWrn = 0; iBurstCh = '0; iBurstBase = '0; iBurstLen = '0;
        iBurstDt = '0; iBurstDtVld = 0;
    endtask

    task automatic clearModel();
        for (int c = 0; c < NC; c++)
            for (int a = 0; a <= AD; a++) model[c][a] = '0;
    endtask

    task automatic sglWrite(input int c, input int a, input logic [DW-1:0] d);
        bit ok = (a >= 1) && (a <= AD) && (c < NC);
        iCsnRam = 0; iWrnRam = 0; iChSel = CW'(c); iAddrRam = AW'(a); iWrDtRam = d;
        @(negedge iClk_12M);
        iCsnRam = 1;
        checkVal("sgl_wr_err", oErr, {31'd0, !ok});
        if (ok) model[c][a] = d;
    endtask

    task automatic sglRead(input int c, input int a);
        bit ok = (a >= 1) && (a <= AD) && (c < NC);
        iCsnRam = 0; iWrnRam = 1; iChSel = CW'(c); iAddrRam = AW'(a);
        @(negedge iClk_12M);
        iCsnRam = 1;
        checkVal("sgl_rd_vld", oRdVld, {31'd0, ok});
        checkVal("sgl_rd_err", oErr, {31'd0, !ok});
        if (ok) checkVal("sgl_rd_data", oRdDtRam, model[c][a]);
    endtask

    task automatic burstWrite(input int c, input int base, input int len,
                              input logic [DW-1:0] d0, input bit seq, input bit inter);
        int a = base;
        logic [DW-1:0] d;
        iBurstStart = 1; iBurstWrn = 0; iBurstCh = CW'(c);
        iBurstBase = AW'(base); iBurstLen = AW'(len);
        @(negedge iClk_12M);
        iBurstStart = 0;
        checkVal("bw_busy", oBusy, 1);
        for (int i = 0; i < len; i++) begin
            if (i == 1 || $urandom_range(0, 3) == 0) begin
                iBurstDtVld = 0;
                if (inter && i == 1) begin
                    iCsnRam = 0; iWrnRam = 0; iChSel = 2'd3; iAddrRam = 6'd7;
                    iWrDtRam = 16'h1234; iClrStart = 1;
                end
                @(negedge iClk_12M);
                if (inter && i == 1) begin
                    iCsnRam = 1; iClrStart = 0;
                    checkVal("bw_ignored_err", oErr, 0);
                    checkVal("bw_ignored_busy", oBusy, 1);
                end
            end
            checkVal("bw_rdy", oBurstDtRdy, 1);
            d = seq ? d0 + DW'(i) : DW'($urandom);
            iBurstDt = d; iBurstDtVld = 1;
            model[c][a] = d;
            a = wrap(a);
            @(negedge iClk_12M);
        end
        iBurstDtVld = 0;
        checkVal("bw_done", oDone, 1);
        checkVal("bw_rdy_drop", oBurstDtRdy, 0);
        @(negedge iClk_12M);
        checkVal("bw_idle", oBusy, 0);
    endtask

    task automatic burstRead(input int c, input int base, input int len);
        int a = base;
        int got = 0;
        int doneAt = -1;
        int first = -1;
        int last = -1;
        iBurstStart = 1; iBurstWrn = 1; iBurstCh = CW'(c);
        iBurstBase = AW'(base); iBurstLen = AW'(len);
        @(negedge iClk_12M);
        iBurstStart = 0;
        for (int k = 0; k < len + 3; k++) begin
            @(negedge iClk_12M);
            if (oBurstRdVld) begin
                if (got < len) checkVal("br_data", oBurstRdDt, model[c][a]);
                a = wrap(a);
                got++;
                if (first < 0) first = k;
                last = k;
                if (oDone) doneAt = got;
            end
        end
        checkVal("br_count", got, len);
        checkVal("br_contig", last - first + 1, len);
        checkVal("br_done_last", doneAt, len);
    endtask

    task automatic burstReject(input int c, input int base, input int len);
        iBurstStart = 1; iBurstWrn = 0; iBurstCh = CW'(c);
        iBurstBase = AW'(base); iBurstLen = AW'(len);
        @(negedge iClk_12M);
        iBurstStart = 0;
        checkVal("rej_err", oErr, 1);
        checkVal("rej_busy", oBusy, 0);
        @(negedge iClk_12M);
        checkVal("rej_err_pulse", oErr, 0);
        checkVal("rej_busy_after", oBusy, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idleInputs();
        iRst = 1;
        repeat (3) @(negedge iClk_12M);
        checkVal("rst_busy", oBusy, 0);
        checkVal("rst_done", oDone, 0);
        checkVal("rst_err", oErr, 0);
        checkVal("rst_rdy", oBurstDtRdy, 0);
        checkVal("rst_rdvld", oRdVld, 0);
        checkVal("rst_brvld", oBurstRdVld, 0);
        iRst = 0;

        busyCnt = 0; doneIdx = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge iClk_12M);
            if (oBusy) busyCnt++;
            if (oDone && doneIdx < 0) doneIdx = i;
        end
        checkVal("clr_busy_cycles", busyCnt, AD);
        checkVal("clr_done_cycle", doneIdx, AD);
        clearModel();

        sglRead(3, 17);
        @(negedge iClk_12M);
        checkVal("rdvld_pulse", oRdVld, 0);

        burstWrite(1, 31, 5, 16'h0011, 1, 0);
        checkVal("model_wrap", model[1][2], 16'h0015);
        sglRead(1, 33);
        sglRead(1, 1);
        burstRead(1, 31, 5);

        sglWrite(0, 5, 16'hFED4);
        sglRead(0, 5);
        @(negedge iClk_12M);
        checkVal("rd_hold", oRdDtRam, 16'hFED4);
        sglRead(1, 5);

        burstReject(1, 31, 0);
        burstReject(1, 31, 34);
        burstReject(1, 0, 5);
        burstReject(1, 34, 5);
        sglRead(1, 31);
        sglRead(1, 2);
        sglRead(1, 0);
        sglWrite(2, 40, 16'h7777);

        repeat (30) begin
            op = $urandom_range(0, 3);
            rc = $urandom_range(0, NC - 1);
            ra = $urandom_range(1, AD);
            rl = $urandom_range(1, AD);
            case (op)
                0: sglWrite(rc, $urandom_range(0, 40), DW'($urandom));
                1: sglRead(rc, $urandom_range(0, 40));
                2: burstWrite(rc, ra, rl, '0, 0, 0);
                default: burstRead(rc, ra, rl);
            endcase
        end

        burstWrite(2, 10, 6, '0, 0, 1);
        sglRead(3, 7);
        burstRead(2, 10, 6);
        sglRead(0, 5);

        iBurstStart = 1; iBurstWrn = 0; iBurstCh = 2'd0; iBurstBase = 6'd1; iBurstLen = 6'd10;
        @(negedge iClk_12M);
        iBurstStart = 0;
        for (int i = 0; i < 3; i++) begin
            iBurstDt = 16'hA5A0 + DW'(i); iBurstDtVld = 1;
            @(negedge iClk_12M);
        end
        iBurstDt = 16'hBEEF;
        iRst = 1;
        #1;
        checkVal("mid_rst_busy", oBusy, 0);
        checkVal("mid_rst_rdy", oBurstDtRdy, 0);
        checkVal("mid_rst_done", oDone, 0);
        checkVal("mid_rst_err", oErr, 0);
        checkVal("mid_rst_rdvld", oRdVld, 0);
        checkVal("mid_rst_rddt", oRdDtRam, 0);
        checkVal("mid_rst_brvld", oBurstRdVld, 0);
        checkVal("mid_rst_brdt", oBurstRdDt, 0);
        idleInputs();
        repeat (2) @(negedge iClk_12M);
        iRst = 0;
        repeat (40) @(negedge iClk_12M);
        checkVal("post_clr_idle", oBusy, 0);
        clearModel();
        for (int a = 1; a <= 4; a++) sglRead(0, a);
        sglRead(0, 5);
        sglRead(3, 33);
        repeat (10) sglRead($urandom_range(0, NC - 1), $urandom_range(1, AD));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
